// File: rtl/seq_alu.sv
// seq_alu: multi-cycle MIPS-style ALU with iterative MUL/DIV and a start/busy/done handshake.
// Define SEQ_ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV (adds a FIX state).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low,
  output logic             ZeroFlag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);
`endif

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic             long_op;
  logic [WIDTH-1:0] fast_lo;
  logic             fast_zf;

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  logic neg_q;
  logic neg_r;
  logic dz;

  assign a_mag = A[WIDTH-1] ? (~A + ONE) : A;
  assign b_mag = B[WIDTH-1] ? (~B + ONE) : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  assign busy    = (state != S_IDLE);
  assign long_op = (Control == OP_MUL) || (Control == OP_DIV);

  // Multiply: {acc,lo} shifts right, adding opnd whenever the low bit is set.
  assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);

  // Restoring divide: the partial remainder stays below the divisor,
  // so the top bit of the difference doubles as the borrow.
  assign div_sh   = {acc, lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ge   = ~div_diff[WIDTH];

  always_comb begin
    fast_lo = '0;
    fast_zf = 1'b0;
    case (Control)
      OP_AND: fast_lo = A & B;
      OP_OR:  fast_lo = A | B;
      OP_ADD: begin
        fast_lo = A + B;
        fast_zf = (fast_lo == '0);
      end
      OP_SUB: begin
        fast_lo = A - B;
        fast_zf = (fast_lo == '0);
      end
      OP_SLT: fast_lo = WIDTH'($signed(A) < $signed(B));
      default: fast_lo = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      done     <= 1'b0;
      High     <= '0;
      Low      <= '0;
      ZeroFlag <= 1'b0;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && long_op) begin
            is_div <= (Control == OP_DIV);
            cnt    <= CNT_INIT;
            acc    <= '0;
            state  <= S_ITER;
            if (Control == OP_DIV) begin
              lo   <= a_mag;
              opnd <= b_mag;
            end else begin
              lo   <= b_mag;
              opnd <= a_mag;
            end
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r <= A[WIDTH-1];
            dz    <= (B == '0);
`endif
          end else if (start) begin
            High     <= '0;
            Low      <= fast_lo;
            ZeroFlag <= fast_zf;
            done     <= 1'b1;
          end
        end
        S_ITER: begin
          if (is_div) begin
            acc <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo  <= {lo[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            lo  <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
            state <= S_FIX;
`else
            state <= S_FIN;
`endif
          end
        end
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        // Divide by zero keeps the all-ones quotient; the remainder
        // negation restores the original A.
        S_FIX: begin
          if (is_div) begin
            if (neg_q && !dz) lo <= ~lo + ONE;
            if (neg_r) acc <= ~acc + ONE;
          end else if (neg_q) begin
            {acc, lo} <= ~{acc, lo} + ONE2;
          end
          state <= S_FIN;
        end
`endif
        S_FIN: begin
          High     <= is_div ? lo : acc;
          Low      <= is_div ? acc : lo;
          ZeroFlag <= 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven scoreboard bench for seq_alu plus
// hand-written back-to-back, ignored-start and mid-op reset sequences.
module tb_seq_alu;

  localparam int W = 32;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
  localparam int LAT = W + 2;
  localparam bit SGN = 1'b1;
`else
  localparam int LAT = W + 1;
  localparam bit SGN = 1'b0;
`endif

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Control;
  logic         busy;
  logic         done;
  logic [W-1:0] High;
  logic [W-1:0] Low;
  logic         ZeroFlag;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Control  (Control),
    .busy     (busy),
    .done     (done),
    .High     (High),
    .Low      (Low),
    .ZeroFlag (ZeroFlag)
  );

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] hi, logic [W-1:0] lo, logic zf);
    vec_t v;
    v.ctrl = c;
    v.a    = a;
    v.b    = b;
    v.hi   = hi;
    v.lo   = lo;
    v.zf   = zf;
    return v;
  endfunction

  // Called at the first negedge after the start edge.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    vec_t e;
    int   lat;
    int   bc;
    int   exp_lat;
    exp_lat = (v.ctrl == OP_MUL || v.ctrl == OP_DIV) ? LAT : 0;
    @(negedge clk);
    A       = v.a;
    B       = v.b;
    Control = v.ctrl;
    start   = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start   = 1'b0;
    A       = $urandom;
    B       = $urandom;
    Control = 4'($urandom);
    wait_done(lat, bc);
    e = sb.pop_front();
    check($sformatf("v%0d_high", idx), High, e.hi);
    check($sformatf("v%0d_low", idx), Low, e.lo);
    check($sformatf("v%0d_zf", idx), W'(ZeroFlag), W'(e.zf));
    check($sformatf("v%0d_latency", idx), W'(lat), W'(exp_lat));
    check($sformatf("v%0d_busy_cycles", idx), W'(bc), W'(exp_lat));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), W'(done), W'(0));
    check($sformatf("v%0d_hold_low", idx), Low, e.lo);
  endtask

  initial begin
    int lat;
    int bc;
    int pulses;

    tbl.push_back(mk(OP_ADD, 5, 7, 0, 12, 0));
    tbl.push_back(mk(OP_SUB, 9, 9, 0, 0, 1));
    tbl.push_back(mk(OP_AND, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0));
    tbl.push_back(mk(OP_OR, 32'hF0, 32'h0F, 0, 32'hFF, 0));
    tbl.push_back(mk(OP_ADD, 32'hFFFFFFFF, 1, 0, 0, 1));
    tbl.push_back(mk(OP_SUB, 3, 5, 0, 32'hFFFFFFFE, 0));
    tbl.push_back(mk(OP_SLT, 32'hFFFFFFFF, 1, 0, 1, 0));
    tbl.push_back(mk(OP_SLT, 1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(4'hF, 32'h55, 32'h66, 0, 0, 0));
    tbl.push_back(mk(4'h5, 32'h1, 32'h1, 0, 0, 0));
    tbl.push_back(mk(OP_MUL, 32'hFFFFFFFF, 2,
                     SGN ? 32'hFFFFFFFF : 32'h1, 32'hFFFFFFFE, 0));
    tbl.push_back(mk(OP_MUL, 32'h10000, 32'h10000, 1, 0, 0));
    tbl.push_back(mk(OP_MUL, 0, 32'h1234, 0, 0, 0));
    tbl.push_back(mk(OP_MUL, 32'hFFFFFFFD, 5,
                     SGN ? 32'hFFFFFFFF : 32'h4, 32'hFFFFFFF1, 0));
    tbl.push_back(mk(OP_DIV, 100, 7, 14, 2, 0));
    tbl.push_back(mk(OP_DIV, 7, 9, 0, 7, 0));
    tbl.push_back(mk(OP_DIV, 32'h1234, 0, 32'hFFFFFFFF, 32'h1234, 0));
    tbl.push_back(mk(OP_DIV, 32'hFFFFFFF9, 2,
                     SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC,
                     SGN ? 32'hFFFFFFFF : 32'h1, 0));

    reset   = 1'b1;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    Control = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_high", High, 0);
    check("rst_low", Low, 0);
    check("rst_zf", W'(ZeroFlag), 0);

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Back-to-back: new start while done is high.
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 2; Control = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("b2b_mul_lat", W'(lat), W'(LAT));
    A = 1; B = 2; Control = OP_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_add_done", W'(done), 1);
    check("b2b_add_low", Low, 3);
    check("b2b_add_high", High, 0);

    // Starts while busy are ignored.
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 2; Control = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      start = (lat == 5 || lat == 20);
      if (start) begin
        A = 1; B = 1; Control = OP_ADD;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ign_lat", W'(lat), W'(LAT));
    check("ign_high", High, SGN ? 32'hFFFFFFFF : 32'h1);
    check("ign_low", Low, 32'hFFFFFFFE);
    @(negedge clk);
    check("ign_no_extra_done", W'(done), 0);

    // Reset in the middle of a MUL.
    A = 32'h1234; B = 32'h5678; Control = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before", W'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_done", W'(done), 0);
    check("mid_rst_high", High, 0);
    check("mid_rst_low", Low, 0);
    pulses = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("mid_rst_no_done", W'(pulses), 0);

    // start together with reset is ignored.
    A = 5; B = 7; Control = OP_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_low", Low, 12);
    A = 1; B = 1; Control = OP_ADD; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("rst_start_low", Low, 0);
    check("rst_start_done", W'(done), 0);
    @(negedge clk);
    check("rst_start_done2", W'(done), 0);
    check("rst_start_low2", Low, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational MIPS ALU.
- Keeps the same Control encoding and the same High/Low/ZeroFlag result convention.
- Computes MUL and DIV iteratively (shift-add multiply, restoring divide) over WIDTH cycles, which removes the large combinational multiplier and divider.
- Uses a start/busy/done handshake and holds its results in registers, so it sits between the MIPS datapath control and the HI/LO register file.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range: 4 or more).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launches an operation. Sampled only in IDLE.
- A  input  WIDTH  operand A. Captured on the accepted start edge.
- B  input  WIDTH  operand B. Captured on the accepted start edge.
- Control  input  4  operation select. Captured on the accepted start edge.
- busy  output  1  high while an operation is in progress. Low in IDLE.
- done  output  1  one-cycle pulse when High, Low and ZeroFlag update.
- High  output  WIDTH  upper result register.
- Low  output  WIDTH  lower result register.
- ZeroFlag  output  1  registered zero flag.

Behaviour:
- Control encoding:
  - 0 AND: Low=A&B, High=0.
  - 1 OR: Low=A|B, High=0.
  - 2 ADD: Low=A+B mod 2^WIDTH, High=0.
  - 3 MUL: {High,Low}=A*B, unsigned, full 2*WIDTH product.
  - 4 DIV: High=A/B quotient, Low=A%B remainder, unsigned.
  - 6 SUB: Low=A-B mod 2^WIDTH, High=0.
  - 7 SLT: Low=1 if signed A<B else 0, High=0.
  - Any other code: High=Low=0, ZeroFlag=0, completes as a single-cycle op.
- ZeroFlag = (Low==0) for ADD and SUB only. It is 0 after every other op.
- States: IDLE, ITER, FIN.
  - IDLE & start & Control in {3,4}: latch operands and Control, counter=WIDTH, go to ITER, busy=1.
  - IDLE & start & any other Control: High, Low and ZeroFlag are written on that same edge. done=1 the next cycle. Stays in IDLE. Latency 1 cycle; busy never rises.
  - ITER: one iteration per cycle, counter decrements. When counter reaches 1, go to FIN on the next edge.
  - FIN: write High and Low, pulse done, busy=0, return to IDLE.
- MUL/DIV latency: start sampled at edge 0; done is high in the cycle after edge WIDTH+1, i.e. WIDTH+1 cycles of busy.
- Back-to-back: start may be asserted in the same cycle that done is high. It is accepted because the FSM is in IDLE.
- start while busy: ignored; no queueing. A, B and Control may change freely while busy.
- Divide by zero: High = all ones, Low = A. Same latency as a normal divide; no exception flag.
- Outputs hold their last value until the next completion. They are never cleared by idle cycles.
- Reset, including in the middle of an operation: on the reset edge:
  - state=IDLE, busy=0, done=0.
  - High=0, Low=0, ZeroFlag=0, counter=0.
  - The partial result is discarded.
  - start asserted together with reset is ignored.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_MULDIV_EN.
- Defined:
  - MUL and DIV treat A and B as two's complement.
  - Operand magnitudes are taken on capture. The unsigned core runs unchanged.
  - The sign fix-up happens in an extra FIX state between ITER and FIN, so latency is WIDTH+2.
  - Product sign = A[MSB]^B[MSB]. Quotient sign = A[MSB]^B[MSB]. Remainder takes the sign of A.
  - Divide by zero still returns High = all ones and Low = A.
- Undefined: unsigned MUL/DIV as above, with no FIX state.

Test Plan:
- ADD A=5 B=7, start for one cycle -> one cycle later done=1, Low=12, High=0, ZeroFlag=0, busy stays 0. Then SUB A=9 B=9 -> Low=0, ZeroFlag=1.
- MUL A=0xFFFFFFFF B=2 (WIDTH=32) -> busy for 33 cycles, done pulse once, High=0x00000001, Low=0xFFFFFFFE. Outputs hold after done.
- DIV A=100 B=7 -> High=14, Low=2 after 33 cycles. DIV A=0x1234 B=0 -> High=0xFFFFFFFF, Low=0x1234.
- SLT A=0xFFFFFFFF B=1 -> Low=1. SLT A=1 B=0xFFFFFFFF -> Low=0. Control=4'hF -> High=Low=0, done after 1 cycle.
- Launch MUL, pulse start with new operands at cycles 5 and 20 -> both ignored, original result returned. Assert reset at cycle 10 of a second MUL -> next cycle busy=0, done=0, High=Low=0, and no done pulse follows.
- With SEQ_ALU_SIGNED_MULDIV_EN: MUL -3*5 -> {High,Low}=-15 sign-extended across 64 bits. DIV -7/2 -> High=-3, Low=-1. Latency 34 cycles.
